// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types for the hazard/forwarding unit
package hazard_pkg;

  localparam int SHADOW_DEPTH = 3;
  localparam int RD_W         = 4;

  typedef enum logic [1:0] {
    FWD_NONE = 2'b00,
    FWD_WB   = 2'b01,
    FWD_MEM  = 2'b10
  } fwd_sel_t;

  typedef struct packed {
    logic            valid;
    logic [RD_W-1:0] rd;
    logic            regWrite;
    logic            isLoad;
  } shadow_entry_t;

endpackage

// File: rtl/forward_compare.sv
// rtl/forward_compare.sv - per-operand source match against E/M (HAZARD_FORWARD_EN selects forwarding)
module forward_compare
  import hazard_pkg::*;
(
  input  logic [RD_W-1:0] rs,
  input  logic            use_rs,
  input  logic            validd,
  input  shadow_entry_t   e_ent,
  input  shadow_entry_t   m_ent,
  output fwd_sel_t        sel,
  output logic            hit
);

  logic e_match;
  logic m_match;
  logic unused_load;

  assign e_match = use_rs & validd & e_ent.valid & e_ent.regWrite & (rs == e_ent.rd);
  assign m_match = use_rs & validd & m_ent.valid & m_ent.regWrite & (rs == m_ent.rd);

  // A load in M already has its data at the WB mux, so only the E-stage load flag matters.
  assign unused_load = e_ent.isLoad ^ m_ent.isLoad;

`ifdef HAZARD_FORWARD_EN
  always_comb begin
    sel = FWD_NONE;
    if (e_match && !e_ent.isLoad)
      sel = FWD_MEM;
    else if (m_match)
      sel = FWD_WB;
  end

  assign hit = e_match & e_ent.isLoad;
`else
  assign sel = FWD_NONE;
  assign hit = e_match | m_match;
`endif

endmodule

// File: rtl/hazard_forward_unit.sv
// rtl/hazard_forward_unit.sv - stall/flush/forward control for D/E/M/W (HAZARD_FORWARD_EN enables forwarding)
module hazard_forward_unit
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = RD_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  validD,
  input  logic [REG_ADDR_W-1:0] rs1D,
  input  logic [REG_ADDR_W-1:0] rs2D,
  input  logic                  use1D,
  input  logic                  use2D,
  input  logic [REG_ADDR_W-1:0] rdD,
  input  logic                  regWriteD,
  input  logic                  memToRegD,
  input  logic                  branchTakenE,
  output logic                  stallF,
  output logic                  stallD,
  output logic                  flushD,
  output logic                  flushE,
  output logic [1:0]            data1ForwardSelector,
  output logic [1:0]            data2ForwardSelector
);

  // Index 0 = E, 1 = M, 2 = W.
  shadow_entry_t shadow [SHADOW_DEPTH];
  shadow_entry_t d_entry;
  fwd_sel_t      sel1, sel2;
  fwd_sel_t      sel1_q, sel2_q;
  logic          hit1, hit2;
  logic          hazard;
  logic          flush_e_int;
  logic          unused_w;

  assign d_entry.valid    = validD;
  assign d_entry.rd       = rdD;
  assign d_entry.regWrite = regWriteD;
  assign d_entry.isLoad   = memToRegD;

  forward_compare u_cmp1 (
    .rs     (rs1D),
    .use_rs (use1D),
    .validd (validD),
    .e_ent  (shadow[0]),
    .m_ent  (shadow[1]),
    .sel    (sel1),
    .hit    (hit1)
  );

  forward_compare u_cmp2 (
    .rs     (rs2D),
    .use_rs (use2D),
    .validd (validD),
    .e_ent  (shadow[0]),
    .m_ent  (shadow[1]),
    .sel    (sel2),
    .hit    (hit2)
  );

  assign hazard      = hit1 | hit2;
  assign flush_e_int = hazard | branchTakenE;

  // A taken branch discards the stalled decode instruction, so it wins over the stall.
  assign stallF = hazard & ~branchTakenE & ~reset;
  assign stallD = hazard & ~branchTakenE & ~reset;
  assign flushD = branchTakenE & ~reset;
  assign flushE = flush_e_int & ~reset;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SHADOW_DEPTH; i++)
        shadow[i] <= '0;
      sel1_q <= FWD_NONE;
      sel2_q <= FWD_NONE;
    end else begin
      shadow[2] <= shadow[1];
      shadow[1] <= shadow[0];
      shadow[0] <= flush_e_int ? '0 : d_entry;
      sel1_q    <= flush_e_int ? FWD_NONE : sel1;
      sel2_q    <= flush_e_int ? FWD_NONE : sel2;
    end
  end

  // The register file writes before it reads, so W is tracked but never compared.
  assign unused_w = ^shadow[2];

  assign data1ForwardSelector = sel1_q;
  assign data2ForwardSelector = sel2_q;

endmodule
